// File: rtl/act_lut_loader_if.sv
// rtl/act_lut_loader_if.sv - load stream handshake between table writer and loader
interface act_lut_loader_if #(
  parameter int DATA_W = 8
);
  logic                     load_valid;
  logic                     load_ready;
  logic signed [DATA_W-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/act_lut_loader.sv
// rtl/act_lut_loader.sv - activation LUT storage with streamed loader and registered read port
module act_lut_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     load_abort,
  act_lut_loader_if.slave          ld,
  output logic                     load_done,
  output logic                     busy,
  output logic                     table_valid,
  input  logic [ADDR_W-1:0]        address,
  output logic signed [DATA_W-1:0] base,
  output logic signed [DATA_W-1:0] next_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic signed [DATA_W-1:0] mem_d [DEPTH];
  logic                     table_valid_q, table_valid_d;
  logic signed [DATA_W-1:0] base_q, base_d;
  logic signed [DATA_W-1:0] next_data_q, next_data_d;
  logic                     wr_en;
  logic [ADDR_W-1:0]        addr_inc;

  assign addr_inc = address + ADDR_W'(1);

  // Next-state, table write and read-port selection; reads see pre-edge contents
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    mem_d         = mem_q;
    table_valid_d = table_valid_q;
    wr_en         = 1'b0;

    base_d      = mem_q[address];
    // The top entry has no successor, so it saturates instead of wrapping to entry 0
    next_data_d = (address == TOP_ADDR) ? mem_q[TOP_ADDR] : mem_q[addr_inc];

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d       = LOAD;
          wr_ptr_d      = '0;
          table_valid_d = 1'b0;
        end
      end
      LOAD: begin
        wr_en = ld.load_valid;
        if (wr_en) begin
          mem_d[wr_ptr_q] = ld.load_data;
          wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
          if (wr_ptr_q == TOP_ADDR) begin
            state_d = DONE;
          end
        end
        // Abort wins over completion; a write in the same cycle still lands
        if (load_abort) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
        end
      end
      DONE: begin
        state_d       = IDLE;
        table_valid_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, table and read registers with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      table_valid_q <= 1'b0;
      base_q        <= '0;
      next_data_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      table_valid_q <= table_valid_d;
      base_q        <= base_d;
      next_data_q   <= next_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign ld.load_ready = (state_q == LOAD);
  assign busy          = (state_q == LOAD);
  assign load_done     = (state_q == DONE);
  assign table_valid   = table_valid_q;
  assign base          = base_q;
  assign next_data     = next_data_q;

endmodule

// File: tb/tb_act_lut_loader.sv
// tb/tb_act_lut_loader.sv - self-checking bench for act_lut_loader
module tb_act_lut_loader;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_start = 1'b0;
  logic              load_abort = 1'b0;
  logic [3:0]        address = 4'd0;
  logic              load_done;
  logic              busy;
  logic              table_valid;
  logic signed [7:0] base;
  logic signed [7:0] next_data;

  int checks = 0;
  int errors = 0;

  act_lut_loader_if #(.DATA_W(8)) lif ();

  act_lut_loader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_abort  (load_abort),
    .ld          (lif.slave),
    .load_done   (load_done),
    .busy        (busy),
    .table_valid (table_valid),
    .address     (address),
    .base        (base),
    .next_data   (next_data)
  );

  always #5 clk = ~clk;

  // Reference model: a plain table plus "loading / entries written / just finished" bookkeeping
  logic signed [7:0] m_mem [16];
  logic signed [7:0] m_base, m_next;
  bit                m_loading, m_just_done, m_tv;
  int                m_count;
  int                m_nidx;

  assign m_nidx = (address == 4'hF) ? 15 : int'(address) + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] <= 8'sd0;
      m_base      <= 8'sd0;
      m_next      <= 8'sd0;
      m_loading   <= 1'b0;
      m_just_done <= 1'b0;
      m_tv        <= 1'b0;
      m_count     <= 0;
    end else begin
      m_base      <= m_mem[address];
      m_next      <= m_mem[m_nidx];
      m_just_done <= 1'b0;
      if (m_just_done) m_tv <= 1'b1;
      if (m_loading) begin
        if (lif.load_valid) begin
          m_mem[m_count] <= lif.load_data;
          m_count        <= m_count + 1;
        end
        if (load_abort) begin
          m_loading <= 1'b0;
        end else if (lif.load_valid && m_count == 15) begin
          m_loading   <= 1'b0;
          m_just_done <= 1'b1;
        end
      end else if (!m_just_done && load_start) begin
        m_loading <= 1'b1;
        m_count   <= 0;
        m_tv      <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Every cycle out of reset, the DUT outputs must equal the model
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("m_base", int'(base), int'(m_base));
      chk("m_next", int'(next_data), int'(m_next));
      chk("m_busy", int'(busy), int'(m_loading));
      chk("m_ready", int'(lif.load_ready), int'(m_loading));
      chk("m_done", int'(load_done), int'(m_just_done));
      chk("m_tv", int'(table_valid), int'(m_tv));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
  endtask

  task automatic rd(input int a, input int eb, input int en);
    address = 4'(a);
    cyc();
    chk("rd_base", int'(base), eb);
    chk("rd_next", int'(next_data), en);
  endtask

  task automatic full_load();
    start_load();
    for (int i = 0; i < 16; i++) begin
      chk("bb_ready", int'(lif.load_ready), 1);
      lif.load_valid = 1'b1;
      lif.load_data  = 8'(i * 8 - 64);
      cyc();
    end
    lif.load_valid = 1'b0;
    chk("bb_done", int'(load_done), 1);
    chk("bb_tv_pre", int'(table_valid), 0);
    cyc();
    chk("bb_done_off", int'(load_done), 0);
    chk("bb_tv", int'(table_valid), 1);
  endtask

  task automatic check_ramp();
    for (int i = 0; i < 16; i++) begin
      rd(i, i * 8 - 64, (i < 15) ? (i + 1) * 8 - 64 : 56);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_base"}, int'(base), 0);
    chk({tag, "_next"}, int'(next_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ready"}, int'(lif.load_ready), 0);
    chk({tag, "_done"}, int'(load_done), 0);
    chk({tag, "_tv"}, int'(table_valid), 0);
  endtask

  initial begin
    int k;
    lif.load_valid = 1'b0;
    lif.load_data  = 8'sd0;

    // Reset and idle read
    repeat (2) cyc();
    check_reset_outputs("rst");
    #4 rst = 1'b1;
    cyc();
    rd(5, 0, 0);
    chk("idle_tv", int'(table_valid), 0);

    // Back-to-back full load and reads
    full_load();
    rd(3, -40, -32);
    rd(15, 56, 56);
    rd(0, -64, -56);

    // Stalled load with a stray load_start in the middle
    start_load();
    k = 0;
    for (int c = 0; c < 32; c++) begin
      if (c <= 30) chk("st_busy", int'(busy), 1);
      if (c == 31) chk("st_done", int'(load_done), 1);
      load_start     = (c == 5);
      lif.load_valid = (c % 2 == 0);
      lif.load_data  = 8'(k * 8 - 64);
      if (c % 2 == 0) k++;
      cyc();
    end
    load_start     = 1'b0;
    lif.load_valid = 1'b0;
    chk("st_tv", int'(table_valid), 1);
    check_ramp();

    // Mid-cycle reset clears everything immediately
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst2");
    #1 rst = 1'b1;
    cyc();

    // Abort after 6 writes of 0x7F
    start_load();
    for (int i = 0; i < 6; i++) begin
      lif.load_valid = 1'b1;
      lif.load_data  = 8'sh7F;
      cyc();
    end
    lif.load_valid = 1'b0;
    load_abort     = 1'b1;
    cyc();
    load_abort = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_tv", int'(table_valid), 0);
    chk("ab_done", int'(load_done), 0);
    repeat (3) cyc();
    rd(4, 127, 127);
    rd(6, 0, 0);
    rd(5, 127, 0);
    chk("ab_tv2", int'(table_valid), 0);

    // Reset in the middle of a load, then a clean reload
    start_load();
    for (int i = 0; i < 10; i++) begin
      lif.load_valid = 1'b1;
      lif.load_data  = 8'(i + 1);
      cyc();
    end
    lif.load_valid = 1'b0;
    #2 rst = 1'b0;
    #1 begin
      chk("rml_busy", int'(busy), 0);
      chk("rml_ready", int'(lif.load_ready), 0);
      chk("rml_tv", int'(table_valid), 0);
    end
    #1 rst = 1'b1;
    cyc();
    for (int i = 0; i < 16; i++) rd(i, 0, 0);
    full_load();
    check_ramp();

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
